// File: rtl/multpool_master.sv
// Command initiator for one multpool slot: writes the packed operand triple,
// waits a configured latency, reads the product back and hands it out.
module multpool_master #(
    parameter int          NBITS    = 128,
    parameter logic [15:0] CFG_ADDR = 16'd0,
    parameter int          LAT_W    = 8
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [NBITS-1:0]     cmd_a,
    input  logic [NBITS-1:0]     cmd_b,
    input  logic [NBITS-1:0]     cmd_m,
    input  logic [LAT_W-1:0]     lat_cfg,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [3*NBITS-1:0]   wdata,
    output logic                 rd_en,
    output logic [31:0]          rd_addr,
    input  logic [3*NBITS-1:0]   rdata,
    input  logic                 rd_ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*NBITS-1:0]   res_data,
    output logic                 err,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [15:0]          done_cnt
);

    // Handshakes: a transfer happens on a rising hclk edge where valid and
    // ready are both high; valid never depends combinationally on ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_nxt;
    logic             accept;
    logic             res_hs;
    logic             unused_rdata_hi;

    // The slot returns only the 2*NBITS product on the result read path.
    assign unused_rdata_hi = ^rdata[3*NBITS-1:2*NBITS];

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && cmd_valid;
    assign res_hs    = (state == S_RESP) && res_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = S_WRITE;
                    cnt_nxt   = lat_cfg;
                end
            end
            S_WRITE: begin
                state_nxt = (cnt == '0) ? S_READ : S_WAIT;
            end
            S_WAIT: begin
                // Entered with cnt=lat_cfg, so exactly lat_cfg WAIT cycles elapse.
                cnt_nxt = cnt - 1'b1;
                if (cnt == LAT_W'(1)) state_nxt = S_READ;
            end
            S_READ: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            res_valid <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
        end else begin
            wr_en     <= (state_nxt == S_WRITE);
            rd_en     <= (state_nxt == S_READ);
            res_valid <= (state_nxt == S_RESP);
            if (state_nxt == S_WRITE) wr_addr <= {16'h0, CFG_ADDR};
            if (state_nxt == S_READ)  rd_addr <= {15'h0, 1'b0, CFG_ADDR};
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wdata <= '0;
        end else if (accept) begin
            wdata <= {cmd_m, cmd_b, cmd_a};
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            res_data <= '0;
            err      <= 1'b0;
        end else begin
            if (state == S_READ) begin
                res_data <= rd_ack ? rdata[2*NBITS-1:0] : '0;
            end
            // A new missing ack wins over a clear in the same cycle.
            if ((state == S_READ) && !rd_ack) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            done_cnt <= '0;
        end else if (res_hs) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_multpool_master.sv
// Directed bench for multpool_master with a small multiply-slot model.
module tb_multpool_master;

  localparam int NB = 128;
  localparam int LW = 8;

  logic              hclk;
  logic              hreset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [NB-1:0]     cmd_a;
  logic [NB-1:0]     cmd_b;
  logic [NB-1:0]     cmd_m;
  logic [LW-1:0]     lat_cfg;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [3*NB-1:0]   wdata;
  logic              rd_en;
  logic [31:0]       rd_addr;
  logic [3*NB-1:0]   rdata;
  logic              rd_ack;
  logic              res_valid;
  logic              res_ready;
  logic [2*NB-1:0]   res_data;
  logic              err;
  logic              err_clr;
  logic              busy;
  logic [15:0]       done_cnt;

  int                total;
  int                bad;
  logic [15:0]       done_exp;
  bit                ack_en;
  logic [2*NB-1:0]   slot_res;

  multpool_master #(.NBITS(NB), .CFG_ADDR(16'd0), .LAT_W(LW)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .lat_cfg(lat_cfg),
    .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata), .rd_ack(rd_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .err_clr(err_clr), .busy(busy), .done_cnt(done_cnt)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // slot model: a write latches a*b, the read port returns it combinationally
  always @(posedge hclk or posedge hreset) begin
    if (hreset) slot_res <= '0;
    else if (wr_en) slot_res <= wdata[NB-1:0] * wdata[2*NB-1:NB];
  end
  assign rdata  = {{NB{1'b1}}, slot_res};
  assign rd_ack = rd_en & ack_en;

  task automatic chk(input string tag, input logic [3*NB-1:0] obs, input logic [3*NB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge hclk);
  endtask

  // One command issued from IDLE with cycle-exact checks of every phase.
  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] m,
                       input int lat, input bit ack, input bit clr_in_read, input int hold,
                       input logic [2*NB-1:0] exp_res, input logic exp_err);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_a = a; cmd_b = b; cmd_m = m; lat_cfg = LW'(lat);
    ack_en = ack; res_ready = 0; cmd_valid = 1;
    step();
    cmd_valid = 0;
    lat_cfg = 8'hFF;
    chk("wr_en_c1", wr_en, 1);
    chk("wdata_c1", wdata, {m, b, a});
    chk("wr_addr_c1", wr_addr, 32'h0);
    chk("rd_en_c1", rd_en, 0);
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("busy_c1", busy, 1);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_no_wr", wr_en, 0);
      chk("wait_no_rd", rd_en, 0);
    end
    step();
    chk("rd_en_read", rd_en, 1);
    chk("rd_addr_read", rd_addr, 32'h0);
    chk("wr_en_read", wr_en, 0);
    err_clr = clr_in_read;
    step();
    err_clr = 0;
    chk("rd_en_resp", rd_en, 0);
    chk("res_valid_resp", res_valid, 1);
    chk("res_data_resp", res_data, exp_res);
    chk("err_resp", err, exp_err);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_res);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_no_wr", wr_en, 0);
    end
    res_ready = 1;
    done_exp = done_exp + 16'd1;
    step();
    res_ready = 0;
    chk("after_valid", res_valid, 0);
    chk("after_idle", busy, 0);
    chk("after_cmd_ready", cmd_ready, 1);
    chk("done_cnt", done_cnt, done_exp);
  endtask

  int wr_cnt;
  int wr_cyc[3];

  initial begin
    total = 0; bad = 0; done_exp = 0;
    hreset = 1; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_m = 0;
    lat_cfg = 0; res_ready = 0; err_clr = 0; ack_en = 1;
    step(); step();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_busy", busy, 0);
    hreset = 0;
    step();

    // single op, lat 4: wr cycle 1, rd cycle 6, valid cycle 7
    do_op(3, 5, 7, 4, 1, 0, 0, 15, 0);
    // zero latency: rd directly after wr
    do_op(11, 13, 17, 0, 1, 0, 0, 143, 0);
    // result backpressure for 10 cycles
    do_op(100, 200, 9, 1, 1, 0, 10, 20000, 0);
    // missing ack: zero result and sticky err, survives a good op
    do_op(6, 7, 9, 2, 0, 0, 0, 0, 1);
    do_op(2, 9, 9, 3, 1, 0, 0, 18, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_cleared", err, 0);
    // clear coinciding with a new error leaves err set
    do_op(4, 4, 9, 1, 0, 1, 0, 0, 1);

    // reset mid-WAIT aborts immediately
    cmd_a = 8; cmd_b = 9; cmd_m = 5; lat_cfg = 6; ack_en = 1; cmd_valid = 1;
    step();
    cmd_valid = 0;
    step(); step();
    chk("pre_rst_busy", busy, 1);
    hreset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", wr_en, 0);
    chk("mid_rst_rd", rd_en, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_done", done_cnt, 0);
    step();
    hreset = 0;
    done_exp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_no_rd", rd_en, 0);
      chk("post_rst_no_wr", wr_en, 0);
    end

    // back-to-back with cmd_valid held: wr pulses at 1, 7, 13
    cmd_a = 2; cmd_b = 3; cmd_m = 5; lat_cfg = 2; res_ready = 1; cmd_valid = 1;
    wr_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (wr_en) begin
        if (wr_cnt < 3) wr_cyc[wr_cnt] = c;
        wr_cnt++;
        if (wr_cnt == 3) cmd_valid = 0;
      end
    end
    cmd_valid = 0; res_ready = 0;
    chk("b2b_count", wr_cnt, 3);
    chk("b2b_wr0", wr_cyc[0], 1);
    chk("b2b_wr1", wr_cyc[1], 7);
    chk("b2b_wr2", wr_cyc[2], 13);
    chk("b2b_done", done_cnt, 3);
    chk("b2b_idle", busy, 0);

    // done counter wrap from 0xFFFF
    force dut.done_cnt = 16'hFFFF;
    step();
    release dut.done_cnt;
    step();
    chk("preload_done", done_cnt, 16'hFFFF);
    done_exp = 16'hFFFF;
    do_op(1, 1, 3, 0, 1, 0, 0, 1, 0);
    chk("wrap_zero", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
